cdm_seq_divider: RTL and testbench

- Iterative restoring divider. It is the inverse-operation counterpart to the carry-disregard adder/multiplier datapath.
- Divides an N-bit unsigned dividend by a D-bit unsigned divisor, one quotient bit per clock.
- Each step uses a ripple-borrow subtractor built from the same full-subtractor cell style as the adder blocks.
- Sits beside the approximate multipliers so the team can recover operands and measure error (product / operand).

---
 rtl/cdm_seq_divider_pkg.sv | 13 +
 rtl/cdm_sub_ripple.sv | 23 ++
 rtl/cdm_seq_divider.sv | 121 ++++++++++++
 tb/tb_cdm_seq_divider.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cdm_seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default widths.
package cdm_seq_divider_pkg;

    localparam int N_W_DEF = 16;
    localparam int D_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/cdm_sub_ripple.sv
// Ripple-borrow subtractor (diff = a - b) built from a chain of full-subtractor cells.
// Purely combinational; bout=1 means a < b.
module cdm_sub_ripple #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W:0] brw;

    assign brw[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_cell
        assign diff[i]  = a[i] ^ b[i] ^ brw[i];
        assign brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end

    assign bout = brw[W];

endmodule

// File: rtl/cdm_seq_divider.sv
// Iterative restoring divider: one quotient bit per clock, N_W steps, results held until next DONE.
// Start is honoured in IDLE and DONE only; a zero divisor completes immediately with div_by_zero.
module cdm_seq_divider
    import cdm_seq_divider_pkg::*;
#(
    parameter int N_W = N_W_DEF,
    parameter int D_W = D_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_by_zero
);

    localparam int CW = $clog2(N_W) + 1;

    div_state_t     state, state_d;
    logic [N_W-1:0] q_sh, q_d;
    logic [D_W-1:0] b_reg, b_d;
    logic [D_W:0]   r, r_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic [N_W-1:0] quo_d;
    logic [D_W-1:0] rem_d;
    logic           dbz_d;

    logic [D_W:0]   sub_a, sub_t;
    logic           sub_brw;
    logic [D_W:0]   r_step;
    logic [N_W-1:0] q_step;
    logic           r_top_unused;

    // Between steps R < B holds, so the top bit of R never feeds the next shift.
    assign r_top_unused = r[D_W];

    assign sub_a = {r[D_W-1:0], q_sh[N_W-1]};

    cdm_sub_ripple #(.W(D_W + 1)) u_sub (
        .a    (sub_a),
        .b    ({1'b0, b_reg}),
        .diff (sub_t),
        .bout (sub_brw)
    );

    assign r_step = sub_brw ? sub_a : sub_t;
    assign q_step = {q_sh[N_W-2:0], ~sub_brw};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            q_sh        <= '0;
            b_reg       <= '0;
            r           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_d;
            q_sh        <= q_d;
            b_reg       <= b_d;
            r           <= r_d;
            cnt         <= cnt_d;
            quotient    <= quo_d;
            remainder   <= rem_d;
            div_by_zero <= dbz_d;
        end
    end

    always_comb begin
        state_d = state;
        q_d     = q_sh;
        b_d     = b_reg;
        r_d     = r;
        cnt_d   = cnt;
        quo_d   = quotient;
        rem_d   = remainder;
        dbz_d   = div_by_zero;
        busy    = (state == S_RUN);
        done    = (state == S_DONE);

        case (state)
            S_RUN: begin
                q_d   = q_step;
                r_d   = r_step;
                cnt_d = cnt + CW'(1);
                if (cnt == CW'(N_W - 1)) begin
                    state_d = S_DONE;
                    quo_d   = q_step;
                    rem_d   = r_step[D_W-1:0];
                end
            end
            default: begin
                // IDLE and DONE both accept a new operation.
                if (start) begin
                    q_d   = dividend;
                    b_d   = divisor;
                    r_d   = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quo_d   = '1;
                        rem_d   = dividend[D_W-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        dbz_d   = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_cdm_seq_divider.sv
// Directed and randomized checks of cdm_seq_divider against integer division.
module tb_cdm_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int total  = 0;
    int passed = 0;

    cdm_seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [15:0] ref_q(input logic [15:0] dd, input logic [7:0] dv);
        return (dv == 0) ? 16'hFFFF : 16'(dd / dv);
    endfunction

    function automatic logic [7:0] ref_r(input logic [15:0] dd, input logic [7:0] dv);
        return (dv == 0) ? dd[7:0] : 8'(dd % dv);
    endfunction

    // Wait (bounded) for done; returns cycle count since acceptance and busy cycles seen.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc = 1;
        busy_cyc = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cyc++;
            tick();
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] dd, input logic [7:0] dv);
        logic [31:0] recon;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_q"}, 32'(quotient), 32'(ref_q(dd, dv)));
        chk({tag, "_r"}, 32'(remainder), 32'(ref_r(dd, dv)));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(dv == 0));
        if (dv != 0) begin
            recon = 32'(quotient) * 32'(dv) + 32'(remainder);
            chk({tag, "_inv"}, recon, 32'(dd));
            chk({tag, "_rlt"}, 32'(remainder < dv), 32'd1);
        end
    endtask

    task automatic do_div(input string tag, input logic [15:0] dd, input logic [7:0] dv);
        int cyc, bc;
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(cyc, bc);
        chk({tag, "_lat"}, 32'(cyc), (dv == 0) ? 32'd1 : 32'd17);
        chk({tag, "_busy"}, 32'(bc), (dv == 0) ? 32'd0 : 32'd16);
        check_result(tag, dd, dv);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc, bc, ndone;
        logic [15:0] dd;
        logic [7:0]  dv;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);

        do_div("d1000_7", 16'd1000, 8'd7);
        do_div("dmax_255", 16'd65535, 8'd255);
        do_div("dmax_1", 16'd65535, 8'd1);
        do_div("d5_10", 16'd5, 8'd10);
        do_div("d100_0", 16'd100, 8'd0);
        do_div("d0_255", 16'd0, 8'd255);

        // Back-to-back: start held high, operands changed mid-run.
        dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
        tick();
        dividend = 16'd300; divisor = 8'd17;
        wait_done(cyc, bc);
        chk("b2b1_lat", 32'(cyc), 32'd17);
        check_result("b2b1", 16'd1000, 8'd7);
        tick();
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_hold_q", 32'(quotient), 32'd142);
        chk("b2b_hold_r", 32'(remainder), 32'd6);
        wait_done(cyc, bc);
        chk("b2b2_lat", 32'(cyc), 32'd17);
        check_result("b2b2", 16'd300, 8'd17);
        tick();

        // Start pulses during RUN are ignored.
        dividend = 16'd2000; divisor = 8'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2 || i == 8) begin
                dividend = 16'd50; divisor = 8'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        wait_done(cyc, bc);
        chk("ign_lat", 32'(cyc + 12), 32'd17);
        check_result("ign", 16'd2000, 8'd9);
        tick();

        // Reset in the middle of a run.
        dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_q", 32'(quotient), 32'd0);
        chk("mid_r", 32'(remainder), 32'd0);
        chk("mid_dbz", 32'(div_by_zero), 32'd0);
        ndone = 0;
        for (int i = 0; i < 24; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("mid_no_done", 32'(ndone), 32'd0);

        // Random sweep with extreme operands mixed in.
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 5))
                0: dv = 8'd0;
                1: dv = 8'd255;
                2: dv = 8'd1;
                default: dv = 8'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: dd = 16'd0;
                1: dd = 16'hFFFF;
                default: dd = 16'($urandom);
            endcase
            do_div("rnd", dd, dv);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
